// File: rtl/ac_channel_fifo_if.sv
// ac_channel_fifo_if: writer/reader handshake bundle for the channel FIFO
interface ac_channel_fifo_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  logic [WIDTH-1:0]           in_data;
  logic [31:0]                write_valid;
  logic                       write_ready;
  logic                       read_valid;
  logic                       read_ready;
  logic [WIDTH-1:0]           out_data;
  logic [$clog2(DEPTH):0]     count;
  logic                       overflow;
  logic                       underflow;
  modport master (
    output in_data, write_valid, read_valid,
    input  write_ready, read_ready, out_data, count, overflow, underflow
  );
  modport slave (
    input  in_data, write_valid, read_valid,
    output write_ready, read_ready, out_data, count, overflow, underflow
  );
endinterface

// File: rtl/ac_channel_fifo.sv
// ac_channel_fifo: circular-buffer channel with registered pop data and sticky over/underflow flags
module ac_channel_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             chan_rst_i,
  ac_channel_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             not_full, not_empty, wr_req, wr_ok, rd_ok;
  always_comb begin
    not_full  = cnt_q != CW'(DEPTH);
    not_empty = cnt_q != '0;
    wr_req    = |bus.write_valid;
    wr_ok     = wr_req && not_full;
    rd_ok     = bus.read_valid && not_empty;
    wp_d      = chan_rst_i ? '0 : wp_q + AW'(wr_ok);
    rp_d      = chan_rst_i ? '0 : rp_q + AW'(rd_ok);
    cnt_d     = chan_rst_i ? '0 : cnt_q + CW'(wr_ok) - CW'(rd_ok);
    out_d     = chan_rst_i ? '0 : rd_ok ? mem_q[rp_q] : out_q;
    ovf_d     = !chan_rst_i && (ovf_q || (wr_req && !not_full));
    unf_d     = !chan_rst_i && (unf_q || (bus.read_valid && !not_empty));
  end
  assign bus.write_ready = not_full;
  assign bus.read_ready  = not_empty;
  assign bus.out_data    = out_q;
  assign bus.count       = cnt_q;
  assign bus.overflow    = ovf_q;
  assign bus.underflow   = unf_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      out_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end
  // storage is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (wr_ok && !chan_rst_i) mem_q[wp_q] <= bus.in_data;
  end
endmodule
